mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/mem_stage_lsu.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store constants, FSM state type and access-size decode for the
// memory-stage LSU.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [3:0] LSU_TIMEOUT_LIM = 4'd15;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Undefined encodings fall back to a full word; LBU/LHU codes mean nothing for stores.
  function automatic lsu_size_t lsu_size(input logic is_store, input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_LB:   sz = SZ_B;
      F3_LH:   sz = SZ_H;
      F3_LBU:  sz = is_store ? SZ_W : SZ_B;
      F3_LHU:  sz = is_store ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to funct3.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  data = {24'd0, lane_b};
      F3_LHU:  data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: IDLE/REQ/WAIT handshake to the data memory
// with byte lanes, load extension and a bus timeout. Misaligned-access
// trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic        bus_err,
  output logic        misalign_err
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;
  logic        done_q, done_d;
  logic        berr_q, berr_d;
  logic        merr_q, merr_d;

  logic        new_req;
  lsu_size_t   sz;
  logic [1:0]  off_in, off_al;
  logic        misaligned, trap;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] ld_aligned;

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_aligned)
  );

  // Decode of the incoming request; only consumed while IDLE.
  always_comb begin
    new_req    = mem_read_in | mem_write_in;
    sz         = lsu_size(mem_write_in, funct3_in);
    off_in     = alu_result_in[1:0];
    misaligned = 1'b0;
    off_al     = 2'b00;
    be_calc    = 4'b1111;
    wdata_calc = rs2_data_in;
    case (sz)
      SZ_B: begin
        off_al     = off_in;
        be_calc    = 4'b0001 << off_al;
        wdata_calc = {4{rs2_data_in[7:0]}};
      end
      SZ_H: begin
        misaligned = off_in[0];
        off_al     = {off_in[1], 1'b0};
        be_calc    = 4'b0011 << off_al;
        wdata_calc = {2{rs2_data_in[15:0]}};
      end
      default: misaligned = (off_in != 2'b00);
    endcase
    trap = TRAP_EN & misaligned;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    berr_d  = 1'b0;
    merr_d  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (new_req) begin
          if (trap) begin
            done_d = 1'b1;
            merr_d = 1'b1;
          end else begin
            state_d = LSU_REQ;
            req_d   = 1'b1;
            we_d    = mem_write_in;
            addr_d  = {alu_result_in[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            off_d   = off_al;
            f3_d    = funct3_in;
            cnt_d   = 4'd0;
          end
        end
      end
      LSU_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          cnt_d = 4'd0;
          if (we_q) begin
            state_d = LSU_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LSU_WAIT;
          end
        end else if (cnt_q == LSU_TIMEOUT_LIM) begin
          state_d = LSU_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = 32'd0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LSU_WAIT: begin
        if (dmem_rvalid) begin
          state_d = LSU_IDLE;
          ld_d    = ld_aligned;
          done_d  = 1'b1;
        end else if (cnt_q == LSU_TIMEOUT_LIM) begin
          state_d = LSU_IDLE;
          ld_d    = 32'd0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      cnt_q   <= 4'd0;
      ld_q    <= 32'd0;
      done_q  <= 1'b0;
      berr_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      berr_q  <= berr_d;
      merr_q  <= merr_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign load_data    = ld_q;
  assign lsu_done     = done_q;
  assign bus_err      = berr_q;
  assign misalign_err = merr_q;
  assign lsu_busy     = (state_q != LSU_IDLE) | new_req;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver pushes expected bus requests and
// completions computed from byte-level arithmetic; a monitor pops and compares.
module tb_mem_stage_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] alu_result_in = '0, rs2_data_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] load_data;
  logic        lsu_done, lsu_busy, bus_err, misalign_err;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .lsu_done(lsu_done), .lsu_busy(lsu_busy),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        berr;
    logic        merr;
    int          t;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_txn = 1'b0;
  logic [31:0] exp_ld = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: access width in bytes, lanes and extension by plain arithmetic.
  function automatic int nbytes(input bit st, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return st ? 4 : 1;
      3'd5: return st ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input int off, input logic [31:0] r);
    int n;
    logic [31:0] v;
    n = nbytes(1'b0, f3);
    v = r >> (8 * off);
    if (n == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdat, input int gd, input int rd);
    int n, lo, off, b;
    bit mis, trap, granted, got;
    req_t rq;
    cpl_t cp;
    n    = nbytes(st, f3);
    lo   = int'(a % 4);
    off  = lo / n * n;
    mis  = (lo % n) != 0;
    trap = TRAP && mis;
    b    = ((1 << n) - 1) << off;
    rq.addr = a & 32'hFFFF_FFFC;
    rq.be   = b[3:0];
    rq.we   = st;
    for (int i = 0; i < 4; i++) rq.wdata[8*i +: 8] = d[8*(i % n) +: 8];
    if (!trap) req_q.push_back(rq);

    @(posedge clk); #1;
    mem_write_in  = st;
    mem_read_in   = !st || ($urandom_range(0, 3) == 0);
    funct3_in     = f3;
    alu_result_in = a;
    rs2_data_in   = d;
    @(posedge clk); #1;
    mem_write_in = 1'b0; mem_read_in = 1'b0;
    funct3_in = 3'($urandom); alu_result_in = $urandom; rs2_data_in = $urandom;

    if (trap) begin
      cp = '{exp_ld, 1'b0, 1'b1, cyc};
      cpl_q.push_back(cp);
    end else begin
      in_txn = 1'b1;
      granted = 1'b0;
      for (int k = 0; k <= 15; k++) begin
        if (k == gd) begin
          dmem_gnt = 1'b1;
          dmem_rvalid = !st;          // must be ignored before WAIT
          dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (k == gd) begin granted = 1'b1; break; end
      end
      if (!granted || st) begin
        if (!granted) exp_ld = '0;
        cp = '{exp_ld, !granted, 1'b0, cyc};
        cpl_q.push_back(cp);
      end else begin
        got = 1'b0;
        for (int k = 0; k <= 15; k++) begin
          if (k == rd) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
          else dmem_rdata = $urandom;
          @(posedge clk); #1;
          dmem_rvalid = 1'b0;
          if (k == rd) begin got = 1'b1; break; end
        end
        exp_ld = got ? ld_val(f3, off, rdat) : 32'd0;
        cp = '{exp_ld, !got, 1'b0, cyc};
        cpl_q.push_back(cp);
      end
      in_txn = 1'b0;
    end
    for (int w = 0; w < 5 && cpl_q.size() != 0; w++) @(negedge clk);
    if (cpl_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout actual=none expected=lsu_done t=%0d", cyc);
      cpl_q.delete();
      req_q.delete();
    end
  endtask

  // Monitor: compares bus requests and completions against the queues.
  initial begin
    req_t cur;
    cpl_t cp;
    logic [31:0] mon_ld;
    bit req_prev;
    cur = '{32'd0, 4'd0, 32'd0, 1'b0};
    mon_ld = '0;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_ld = '0;
        req_prev = 1'b0;
      end else begin
        chk("lsu_busy", 32'(lsu_busy), 32'(in_txn || mem_read_in || mem_write_in));
        if (dmem_req) begin
          if (!req_prev) begin
            if (req_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_req actual=dmem_req expected=none t=%0d", cyc);
            end else cur = req_q.pop_front();
          end
          chk("dmem_addr", dmem_addr, cur.addr);
          chk("dmem_be", 32'(dmem_be), 32'(cur.be));
          chk("dmem_we", 32'(dmem_we), 32'(cur.we));
          if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
        end
        req_prev = dmem_req;
        if (lsu_done) begin
          if (cpl_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done actual=lsu_done expected=none t=%0d", cyc);
          end else begin
            cp = cpl_q.pop_front();
            chk("done_cycle", cyc, cp.t);
            chk("load_data", load_data, cp.ld);
            chk("bus_err", 32'(bus_err), 32'(cp.berr));
            chk("misalign_err", 32'(misalign_err), 32'(cp.merr));
            mon_ld = cp.ld;
          end
        end else begin
          chk("err_idle", 32'({bus_err, misalign_err}), 32'd0);
          chk("load_hold", load_data, mon_ld);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_be"}, 32'(dmem_be), 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_ld"}, load_data, 32'd0);
    chk({tag, "_pulses"}, 32'({lsu_done, bus_err, misalign_err, lsu_busy}), 32'd0);
  endtask

  task automatic reset_in_wait();
    req_t rq;
    rq = '{32'h300, 4'b1111, 32'd0, 1'b0};
    req_q.push_back(rq);
    @(posedge clk); #1;
    mem_read_in = 1'b1; funct3_in = 3'd2; alu_result_in = 32'h300;
    @(posedge clk); #1;
    mem_read_in = 1'b0;
    in_txn = 1'b1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #2;                // in WAIT, rvalid withheld
    rst_n = 1'b0;
    in_txn = 1'b0;
    exp_ld = '0;
    #1;
    check_reset_outputs("rst_wait");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);        // monitor flags any stray lsu_done
  endtask

  initial begin
    logic [2:0] f3;
    int g, r, sel;
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, 0);
    run_txn(1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1, 0);
    run_txn(1'b0, 3'd0, 32'h202, 32'h0, 32'h0080FF00, 0, 2);
    run_txn(1'b0, 3'd5, 32'h202, 32'h0, 32'h0080FF00, 1, 0);
    run_txn(1'b0, 3'd2, 32'h400, 32'h0, 32'h12345678, 0, 20);
    run_txn(1'b0, 3'd4, 32'h401, 32'h0, 32'h0000AB00, 0, 1);
    run_txn(1'b1, 3'd2, 32'h500, 32'h11112222, 32'h0, 15, 0);
    run_txn(1'b1, 3'd1, 32'h502, 32'h0000BEEF, 32'h0, 20, 0);
    run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 1, 15);
    run_txn(1'b0, 3'd1, 32'h203, 32'h0, 32'h8001_7FFF, 0, 0);
    run_txn(1'b1, 3'd7, 32'h602, 32'hA1B2C3D4, 32'h0, 0, 0);
    reset_in_wait();
    run_txn(1'b0, 3'd2, 32'h700, 32'h0, 32'h55AA55AA, 0, 0);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom);
      sel = $urandom_range(0, 9);
      g = (sel < 6) ? sel % 4 : (sel < 8) ? 1 : (sel == 8) ? 15 : 16;
      sel = $urandom_range(0, 9);
      r = (sel < 6) ? sel % 4 : (sel < 8) ? 0 : (sel == 8) ? 15 : 16;
      run_txn(1'($urandom), f3, $urandom, $urandom, $urandom, g, r);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
